image_tile_dispatcher: RTL and testbench

- Avalon-MM slave peripheral inside image_parallel_processing_qsys, on the same fabric as the SDRAM controller.
- Hands out image tile indices to both NIOS processors. Each CPU atomically claims the next unprocessed tile by reading one register, then reports completion by writing another.
- Raises an interrupt when every tile of the frame is complete, so SDRAM-resident image work is split without software mutexes.

---
 rtl/image_tile_dispatcher.sv | 151 +++++++++++++++
 tb/tb_image_tile_dispatcher.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/image_tile_dispatcher.sv
// ============================================================================
//  Module   : image_tile_dispatcher
//  Purpose  : Avalon-MM tile-index dispatcher shared by two CPUs; claims are
//             atomic single-read operations, completion raises an interrupt.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module image_tile_dispatcher #(
    parameter int IDX_W = 16,
    parameter int RDLAT = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq,
    output logic        busy
);

    localparam logic [1:0]  C_IDLE = 2'd0;
    localparam logic [1:0]  C_RUN  = 2'd1;
    localparam logic [1:0]  C_DONE = 2'd2;
    localparam logic [31:0] C_ID   = 32'h1D15_0001;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] total_q, total_d;
    logic [IDX_W-1:0] issued_q, issued_d;
    logic [IDX_W-1:0] completed_q, completed_d;
    logic             irq_pending_q, irq_pending_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic w_wr, w_rd, w_ctrl_wr, w_abort, w_go, w_finish;
    logic w_claim_ok, w_comp_wr, w_comp_ok, w_irq_set, w_irq_clr;
    logic w_done;
    logic w_unused;

    // A write in the same cycle as a read wins; the read is simply dropped.
    assign w_wr       = avs_write;
    assign w_rd       = avs_read & ~avs_write;
    assign w_ctrl_wr  = w_wr && (avs_address == 3'd0);
    assign w_abort    = w_ctrl_wr && avs_writedata[1];
    assign w_go       = w_ctrl_wr && avs_writedata[0] && !w_abort && (state_q != C_RUN);
    assign w_finish   = (state_q == C_RUN) && (completed_q == total_q);
    assign w_claim_ok = (state_q == C_RUN) && (issued_q < total_q);
    assign w_comp_wr  = w_wr && (avs_address == 3'd3);
    assign w_comp_ok  = (state_q == C_RUN) && (completed_q < issued_q);
    assign w_irq_clr  = w_wr && (avs_address == 3'd6);
    assign w_irq_set  = (w_go && (total_q == '0)) || (w_finish && !w_abort) ||
                        (w_comp_wr && !w_comp_ok);

    assign w_unused = &{1'b0, avs_writedata[31:IDX_W], (RDLAT == 1)};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= C_IDLE;
            total_q       <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            irq_pending_q <= 1'b0;
            err_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            issued_q      <= issued_d;
            completed_q   <= completed_d;
            irq_pending_q <= irq_pending_d;
            err_q         <= err_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_abort) begin
            state_d = C_IDLE;
        end else if (w_go) begin
            state_d = (total_q != '0) ? C_RUN : C_DONE;
        end else if (w_finish) begin
            state_d = C_DONE;
        end
    end

    always_comb begin
        busy   = (state_q == C_RUN);
        w_done = (state_q == C_DONE);
    end

    always_comb begin
        total_d       = total_q;
        issued_d      = issued_q;
        completed_d   = completed_q;
        irq_pending_d = irq_pending_q;
        err_d         = err_q;
        rvalid_d      = w_rd;
        rdata_d       = rdata_q;

        if (w_wr && (avs_address == 3'd1) && (state_q != C_RUN)) begin
            total_d = avs_writedata[IDX_W-1:0];
        end

        if (w_go) begin
            issued_d    = '0;
            completed_d = '0;
        end else begin
            if (w_rd && (avs_address == 3'd2) && w_claim_ok) begin
                issued_d = issued_q + IDX_W'(1);
            end
            if (w_comp_wr && w_comp_ok) begin
                completed_d = completed_q + IDX_W'(1);
            end
        end

        // Clear beats a simultaneous set so software never loses a clear.
        if (w_irq_clr) begin
            irq_pending_d = 1'b0;
            err_d         = 1'b0;
        end else begin
            irq_pending_d = irq_pending_q | w_irq_set;
            err_d         = err_q | (w_comp_wr && !w_comp_ok);
        end

        if (w_rd) begin
            case (avs_address)
                3'd0:    rdata_d = {28'd0, err_q, irq_pending_q, w_done, busy};
                3'd1:    rdata_d = 32'(total_q);
                3'd2:    rdata_d = w_claim_ok ? (32'(issued_q) | 32'h8000_0000) : 32'd0;
                3'd4:    rdata_d = 32'(issued_q);
                3'd5:    rdata_d = 32'(completed_q);
                3'd7:    rdata_d = C_ID;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_image_tile_dispatcher.sv
// ============================================================================
//  Module   : tb_image_tile_dispatcher
//  Purpose  : Scoreboard bench for image_tile_dispatcher with a cycle-level
//             reference model of the register map and frame rules.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_image_tile_dispatcher;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        irq;
    logic        busy;

    image_tile_dispatcher #(.IDX_W(16), .RDLAT(1)) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .irq               (irq),
        .busy              (busy)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];

    // Reference model: frame status as flags and plain integer counters.
    bit m_run = 0, m_done = 0, m_irq = 0, m_err = 0;
    int m_total = 0, m_iss = 0, m_comp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_irq = 0; m_err = 0;
        m_total = 0; m_iss = 0; m_comp = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
        bit pre_run, fin, set, clr;
        logic [31:0] ex;
        pre_run = m_run;
        fin = m_run && (m_comp == m_total);
        set = 0; clr = 0; ex = 0;
        if (rd && !wr) begin
            case (a)
                3'd0: ex = {28'd0, m_err, m_irq, m_done, m_run};
                3'd1: ex = m_total;
                3'd2: if (m_run && m_iss < m_total) begin
                          ex = 32'h8000_0000 | m_iss;
                          m_iss++;
                      end
                3'd4: ex = m_iss;
                3'd5: ex = m_comp;
                3'd7: ex = 32'h1D15_0001;
                default: ex = 0;
            endcase
            exp_q.push_back(ex);
        end
        if (fin) begin m_run = 0; m_done = 1; set = 1; end
        if (wr) begin
            case (a)
                3'd0: if (d[1]) begin
                          m_run = 0; m_done = 0; set = 0;
                      end else if (d[0] && !pre_run) begin
                          m_iss = 0; m_comp = 0;
                          if (m_total > 0) begin m_run = 1; m_done = 0; end
                          else begin m_done = 1; set = 1; end
                      end
                3'd1: if (!pre_run) m_total = int'(d[15:0]);
                3'd3: if (pre_run && m_comp < m_iss) m_comp++;
                      else begin m_err = 1; set = 1; end
                3'd6: clr = 1;
                default: ;
            endcase
        end
        if (clr) begin m_irq = 0; m_err = 0; end
        else if (set) m_irq = 1;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
        @(posedge clk_clk);
        model_step(rd, wr, a, d);
    endtask

    task automatic rd(input logic [2:0] a);                    bus(1, 0, a, 0); endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); bus(0, 1, a, d); endtask
    task automatic idle();                                     bus(0, 0, 0, 0); endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        idle();
        #3 reset_reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_clk);
        #4 reset_reset_n = 1'b1;
    endtask

    // Monitor: every read expectation must be met on the very next cycle.
    always @(negedge clk_clk) begin
        if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL rdvalid_unexpected: got data %h expected no response", avs_readdata);
            end else begin
                check("readdata", avs_readdata, exp_q.pop_front());
            end
        end else if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL rdvalid_missing: got no response expected %h", exp_q.pop_front());
        end
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("busy", {31'd0, busy}, {31'd0, m_run});
    end

    initial begin
        #17 reset_reset_n = 1'b1;

        rd(7); rd(0); idle();

        wr(1, 3); wr(0, 1);
        repeat (4) rd(2);
        rd(4);
        repeat (3) wr(3, 0);
        idle(); idle();
        rd(0); wr(6, 0); rd(0);

        wr(0, 1); rd(2); wr(3, 0); wr(3, 0);
        rd(5); rd(0);
        wr(0, 2); rd(4); rd(0);

        wr(6, 0); wr(1, 0); wr(0, 1); idle(); idle(); rd(0);
        wr(6, 0); wr(1, 5); wr(0, 1); wr(1, 9); rd(1);
        wr(0, 3); rd(0);

        wr(1, 4); wr(0, 1);
        rd(2); rd(2); wr(3, 0); rd(2);
        async_reset();
        for (int a = 0; a < 8; a++) rd(3'(a));
        wr(1, 2); wr(0, 1); rd(2); rd(2); rd(2);
        wr(3, 0); wr(3, 0); idle(); idle(); rd(0); wr(6, 0);

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (i == 700) async_reset();
            if      (r < 30) rd(2);
            else if (r < 50) wr(3, $urandom);
            else if (r < 55) wr(0, 1);
            else if (r < 56) wr(0, 2);
            else if (r < 57) wr(0, 3);
            else if (r < 62) wr(1, $urandom_range(0, 5));
            else if (r < 65) wr(6, 0);
            else if (r < 80) rd(3'($urandom_range(0, 7)));
            else if (r < 85) bus(1, 1, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
            else idle();
        end

        idle(); idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
